// File: rtl/add_nibble_serial.sv
// add_nibble_serial: multi-cycle wide adder that steps one shared add4 across the operand, LSB nibble first.
// add4 is the purely combinational 4-bit ripple slice it sequences.

module add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

module add_nibble_serial #(
   parameter int NIBBLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   ci,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   s,
   output logic                   co
);
   localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
   logic [1:0] state;
   logic [4*NIBBLES-1:0] ra, rb;
   logic carry;
   logic [IW-1:0] idx;
   logic [3:0] ns;
   logic nco;
   add4 u_add4 (
      .a  (ra[{idx, 2'b00} +: 4]),
      .b  (rb[{idx, 2'b00} +: 4]),
      .ci (carry),
      .s  (ns),
      .co (nco)
   );
   assign busy = state == RUN;
   assign done = state == FIN;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ra    <= '0;
         rb    <= '0;
         carry <= 1'b0;
         idx   <= '0;
         s     <= '0;
         co    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               ra    <= a;
               rb    <= b;
               carry <= ci;
               idx   <= '0;
               s     <= '0;
               state <= RUN;
            end
            RUN: begin
               s[{idx, 2'b00} +: 4] <= ns;
               carry <= nco;
               idx   <= idx + IW'(1);
               // the final slice's carry becomes the visible carry-out
               if (idx == LAST) begin
                  co    <= nco;
                  state <= FIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add_nibble_serial.sv
// tb_add_nibble_serial: directed and random checks of the serial adder at 2 and 4 nibbles
// against plain integer addition.

module tb_add_nibble_serial;
   logic clk = 1'b0, rst = 1'b1;
   logic start2 = 1'b0, start4 = 1'b0, ci = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic busy2, done2, co2, busy4, done4, co4;
   logic [7:0] s2;
   logic [15:0] s4;
   int passes = 0, total = 0;

   always #5 clk = ~clk;

   add_nibble_serial #(.NIBBLES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a[7:0]), .b(b[7:0]), .ci(ci),
      .busy(busy2), .done(done2), .s(s2), .co(co2)
   );
   add_nibble_serial #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .ci(ci),
      .busy(busy4), .done(done4), .s(s4), .co(co4)
   );

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [16:0] model(input int n, input logic [15:0] x, input logic [15:0] y, input logic c);
      longint m = (64'd1 << (4 * n)) - 1;
      longint r = (longint'(x) & m) + (longint'(y) & m) + longint'(c);
      return {r[4*n] == 1'b1, 16'(r & m)};
   endfunction

   function automatic logic [16:0] res(input int n);
      return n == 2 ? {co2, 8'h00, s2} : {co4, s4};
   endfunction

   task automatic op(input int n, input logic [15:0] x, input logic [15:0] y, input logic c, input string tag);
      int k = 0;
      @(negedge clk);
      a = x; b = y; ci = c;
      if (n == 2) start2 = 1'b1; else start4 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0; start4 = 1'b0;
      a = ~x; b = ~y;
      chk({tag, "_busy"}, 17'(n == 2 ? busy2 : busy4), 17'd1);
      while (!(n == 2 ? done2 : done4) && k < 20) begin
         @(posedge clk); #1; k++;
      end
      chk({tag, "_lat"}, 17'(k), 17'(n));
      chk({tag, "_sum"}, res(n), model(n, x, y, c));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {15'd0, n == 2 ? done2 : done4, n == 2 ? busy2 : busy4}, 17'd0);
   endtask

   initial begin
      #3;
      chk("reset", {busy2, done2, co2, s2, busy4, done4, co4, 3'd0}, 17'd0);
      chk("reset4", {1'b0, s4}, 17'd0);
      @(negedge clk); rst = 1'b0;
      op(2, 16'h0F, 16'h01, 1'b0, "t1");
      op(2, 16'hFF, 16'h01, 1'b0, "t2");
      op(2, 16'hFF, 16'hFF, 1'b1, "t3a");
      op(2, 16'h12, 16'h34, 1'b0, "t3b");
      chk("t3b_exact", res(2), 17'h00046);
      // second start while busy must be dropped and never queued
      @(negedge clk); a = 16'h01; b = 16'h01; ci = 1'b0; start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      @(negedge clk); a = 16'hFF; b = 16'hFF; start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      @(posedge clk); #1;
      chk("t4_done", {16'd0, done2}, 17'd1);
      chk("t4_sum", res(2), 17'h00002);
      @(posedge clk); #1;
      chk("t4_single", {15'd0, done2, busy2}, 17'd0);
      @(posedge clk); #1;
      chk("t4_noqueue", {15'd0, done2, busy2}, 17'd0);
      // asynchronous reset between edges in the middle of an operation
      @(negedge clk); a = 16'h1111; b = 16'h2222; ci = 1'b1; start4 = 1'b1;
      @(posedge clk); #1; start4 = 1'b0;
      @(posedge clk); #3;
      chk("t5_mid", {15'd0, busy4, |s4}, 17'd3);
      rst = 1'b1; #1;
      chk("t5_rst", {busy4, done4, co4, s4[13:0]}, 17'd0);
      chk("t5_rst_hi", {busy2, done2, co2, 12'd0, s4[15:14]}, 17'd0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("t5_nodone", {15'd0, done4, busy4}, 17'd0);
      end
      op(4, 16'h1111, 16'h2222, 1'b1, "t5_after");
      op(4, 16'hFFFF, 16'h0001, 1'b0, "t6");
      chk("t6_exact", res(4), 17'h10000);
      for (int i = 0; i < 1000; i++)
         op(i % 2 == 0 ? 2 : 4, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rnd");
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
